// File: rtl/scaler_read_pkg.sv
// Shared definitions for the scaler read arbiter.
//   ADDR_W         : scaler RAM word address width
//   RD_LATENCY_DEF : default clocks from a sampled read strobe to valid data
//   ST_*           : arbiter state encodings (3-bit), exposed on dbg_state_o
package scaler_read_pkg;

  localparam int ADDR_W         = 8;
  localparam int RD_LATENCY_DEF = 2;

  typedef logic [2:0] state_t;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_WB_RD    = 3'd1;
  localparam logic [2:0] ST_WB_WAIT  = 3'd2;
  localparam logic [2:0] ST_WB_ACK   = 3'd3;
  localparam logic [2:0] ST_DMP_RD   = 3'd4;
  localparam logic [2:0] ST_DMP_WAIT = 3'd5;
  localparam logic [2:0] ST_DMP_OUT  = 3'd6;

endpackage

// File: rtl/scaler_dump_seq.sv
// Dump sequencer: tracks the active dump, the beat index, the latched write
// bank, the torn flag and the sticky overrun flag. Only built when the
// SCALER_DUMP_EN macro is defined.
// Ports:
//   clk_i, rst_n_i      : clock, asynchronous active-low reset
//   done_i, dump_en_i   : update-complete pulse, dump enable
//   write_bank_i        : live scaler write bank
//   beat_done_i         : stream handshake on the current beat
//   active_o, idx_o     : dump in progress, current beat index
//   last_o, tuser_o     : current beat is the last one, bank changed during dump
//   overrun_o           : sticky, set by done_i while a dump is running
`ifdef SCALER_DUMP_EN
module scaler_dump_seq
  import scaler_read_pkg::*;
#(
  parameter int NADDR = 48
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              done_i,
  input  logic              dump_en_i,
  input  logic              write_bank_i,
  input  logic              beat_done_i,
  output logic              active_o,
  output logic [ADDR_W-1:0] idx_o,
  output logic              last_o,
  output logic              tuser_o,
  output logic              overrun_o
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NADDR - 1);

  logic              active_q;
  logic [ADDR_W-1:0] idx_q;
  logic              bank_q;
  logic              torn_q;
  logic              overrun_q;
  logic              bank_diff;

  assign bank_diff = active_q & (write_bank_i != bank_q);
  assign active_o  = active_q;
  assign idx_o     = idx_q;
  assign last_o    = (idx_q == LAST_IDX);
  // Include the current cycle so a bank flip on the last beat still counts.
  assign tuser_o   = torn_q | bank_diff;
  assign overrun_o = overrun_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      active_q  <= 1'b0;
      idx_q     <= '0;
      bank_q    <= 1'b0;
      torn_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (done_i && active_q) overrun_q <= 1'b1;
      if (done_i && dump_en_i && !active_q) begin
        active_q <= 1'b1;
        idx_q    <= '0;
        bank_q   <= write_bank_i;
        torn_q   <= 1'b0;
      end else if (active_q) begin
        if (bank_diff) torn_q <= 1'b1;
        if (beat_done_i) begin
          if (last_o) active_q <= 1'b0;
          else        idx_q    <= idx_q + 1'b1;
        end
      end
    end
  end

endmodule
`endif

// File: rtl/scaler_read_arb.sv
// Arbitrates the shared scaler RAM read port between a classic Wishbone
// slave and an automatic dump engine streaming the RAM out on an AXI-stream
// style port. The dump engine exists only when SCALER_DUMP_EN is defined;
// otherwise the stream outputs and overrun flag are tied low.
// Ports:
//   wb_clk_i, wb_rst_n_i            : clock, asynchronous active-low reset
//   wb_cyc/stb/we/adr_i, wb_ack/dat_o : Wishbone slave
//   scal_rd_o, scal_adr_o, scal_dat_i : scaler RAM read port
//   done_i, write_bank_i, dump_en_i   : dump trigger, bank, enable
//   m_tdata/tvalid/tlast/tuser, m_tready : dump stream
//   dump_overrun_o                    : sticky overrun flag
//   dbg_state_o                       : current arbiter state
// Stream handshake: a beat transfers on a rising edge where m_tvalid and
// m_tready are both high; m_tvalid never drops and m_tdata never changes
// before that edge.
module scaler_read_arb
  import scaler_read_pkg::*;
#(
  parameter int NADDR      = 48,
  parameter int RD_LATENCY = RD_LATENCY_DEF
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_n_i,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  input  logic              wb_we_i,
  input  logic [ADDR_W-1:0] wb_adr_i,
  output logic              wb_ack_o,
  output logic [31:0]       wb_dat_o,
  output logic              scal_rd_o,
  output logic [ADDR_W-1:0] scal_adr_o,
  input  logic [31:0]       scal_dat_i,
  input  logic              done_i,
  input  logic              write_bank_i,
  input  logic              dump_en_i,
  output logic [31:0]       m_tdata,
  output logic              m_tvalid,
  output logic              m_tlast,
  output logic              m_tuser,
  input  logic              m_tready,
  output logic              dump_overrun_o,
  output logic [2:0]        dbg_state_o
);

  localparam logic [1:0] LAT_LAST = 2'(RD_LATENCY - 1);

  state_t      state_q, state_d;
  logic        fair_q, fair_d;    // 0: WB wins the next contested grant
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] hold_q, hold_d;
  logic        wr_q, wr_d;        // current WB cycle is a write
  logic        abort_q, abort_d;  // master dropped the read before ack
  logic        wb_req;
  logic        dump_active;
  logic        grant_wb;

  assign wb_req   = wb_cyc_i & wb_stb_i;
  assign grant_wb = wb_req & (~dump_active | ~fair_q);

`ifdef SCALER_DUMP_EN
  logic              grant_dmp;
  logic              beat_done;
  logic [ADDR_W-1:0] dump_idx;
  logic              seq_last;
  logic              seq_tuser;

  assign grant_dmp = dump_active & (~wb_req | fair_q);
  assign beat_done = (state_q == ST_DMP_OUT) & m_tready;

  scaler_dump_seq #(.NADDR(NADDR)) u_dump_seq (
    .clk_i        (wb_clk_i),
    .rst_n_i      (wb_rst_n_i),
    .done_i       (done_i),
    .dump_en_i    (dump_en_i),
    .write_bank_i (write_bank_i),
    .beat_done_i  (beat_done),
    .active_o     (dump_active),
    .idx_o        (dump_idx),
    .last_o       (seq_last),
    .tuser_o      (seq_tuser),
    .overrun_o    (dump_overrun_o)
  );

  assign m_tvalid   = (state_q == ST_DMP_OUT);
  assign m_tdata    = m_tvalid ? hold_q : '0;
  assign m_tlast    = m_tvalid & seq_last;
  assign m_tuser    = m_tlast & seq_tuser;
  assign scal_rd_o  = (state_q == ST_WB_RD) | (state_q == ST_DMP_RD);
  assign scal_adr_o = (state_q == ST_WB_RD)  ? wb_adr_i :
                      (state_q == ST_DMP_RD) ? dump_idx : '0;
`else
  logic unused_dump_ins;

  assign dump_active     = 1'b0;
  assign unused_dump_ins = ^{done_i, write_bank_i, dump_en_i, m_tready, NADDR > 0};
  assign m_tvalid        = 1'b0;
  assign m_tdata         = '0;
  assign m_tlast         = 1'b0;
  assign m_tuser         = 1'b0;
  assign dump_overrun_o  = 1'b0;
  assign scal_rd_o       = (state_q == ST_WB_RD);
  assign scal_adr_o      = (state_q == ST_WB_RD) ? wb_adr_i : '0;
`endif

  assign wb_ack_o    = (state_q == ST_WB_ACK);
  assign wb_dat_o    = (wb_ack_o && !wr_q) ? hold_q : '0;
  assign dbg_state_o = state_q;

  always_comb begin
    state_d = state_q;
    fair_d  = fair_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    wr_d    = wr_q;
    abort_d = abort_q;
    case (state_q)
      ST_IDLE: begin
        if (wb_req && dump_active) fair_d = ~fair_q;
        if (grant_wb) begin
          wr_d    = wb_we_i;
          abort_d = 1'b0;
          // Writes touch no RAM and ack on the next cycle.
          state_d = wb_we_i ? ST_WB_ACK : ST_WB_RD;
        end
`ifdef SCALER_DUMP_EN
        else if (grant_dmp) begin
          state_d = ST_DMP_RD;
        end
`endif
      end
      ST_WB_RD: begin
        cnt_d   = '0;
        abort_d = abort_q | ~wb_req;
        state_d = ST_WB_WAIT;
      end
      ST_WB_WAIT: begin
        abort_d = abort_q | ~wb_req;
        if (cnt_q == LAT_LAST) begin
          hold_d  = scal_dat_i;
          state_d = (abort_q || !wb_req) ? ST_IDLE : ST_WB_ACK;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      ST_WB_ACK: state_d = ST_IDLE;
`ifdef SCALER_DUMP_EN
      ST_DMP_RD: begin
        cnt_d   = '0;
        state_d = ST_DMP_WAIT;
      end
      ST_DMP_WAIT: begin
        if (cnt_q == LAT_LAST) begin
          hold_d  = scal_dat_i;
          state_d = ST_DMP_OUT;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      ST_DMP_OUT: if (m_tready) state_d = ST_IDLE;
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q <= ST_IDLE;
      fair_q  <= 1'b0;
      cnt_q   <= '0;
      hold_q  <= '0;
      wr_q    <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fair_q  <= fair_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      wr_q    <= wr_d;
      abort_q <= abort_d;
    end
  end

endmodule

// File: tb/tb_scaler_read_arb.sv
module tb_scaler_read_arb;
  import scaler_read_pkg::*;

  localparam int NADDR = 48;
  localparam int LAT   = 2;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        wb_rst_n;
  logic        wb_cyc, wb_stb, wb_we;
  logic [7:0]  wb_adr;
  logic        wb_ack_o;
  logic [31:0] wb_dat_o;
  logic        scal_rd_o;
  logic [7:0]  scal_adr_o;
  logic [31:0] scal_dat;
  logic        done, write_bank, dump_en;
  logic [31:0] m_tdata;
  logic        m_tvalid, m_tlast, m_tuser, m_tready;
  logic        dump_overrun_o;
  logic [2:0]  dbg_state_o;

  scaler_read_arb #(.NADDR(NADDR), .RD_LATENCY(LAT)) dut (
    .wb_clk_i       (clk),
    .wb_rst_n_i     (wb_rst_n),
    .wb_cyc_i       (wb_cyc),
    .wb_stb_i       (wb_stb),
    .wb_we_i        (wb_we),
    .wb_adr_i       (wb_adr),
    .wb_ack_o       (wb_ack_o),
    .wb_dat_o       (wb_dat_o),
    .scal_rd_o      (scal_rd_o),
    .scal_adr_o     (scal_adr_o),
    .scal_dat_i     (scal_dat),
    .done_i         (done),
    .write_bank_i   (write_bank),
    .dump_en_i      (dump_en),
    .m_tdata        (m_tdata),
    .m_tvalid       (m_tvalid),
    .m_tlast        (m_tlast),
    .m_tuser        (m_tuser),
    .m_tready       (m_tready),
    .dump_overrun_o (dump_overrun_o),
    .dbg_state_o    (dbg_state_o)
  );

  // scaler RAM model: data appears LAT clocks after the read strobe is sampled
  logic [31:0] ram [0:255];
  logic [31:0] pipe [0:LAT-1];
  always @(posedge clk) begin
    pipe[0] <= scal_rd_o ? ram[scal_adr_o] : 32'hDEAD_BEEF;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign scal_dat = pipe[LAT-1];

  // scoreboard
  logic [31:0] exp_q[$];   // Wishbone read data
  logic [31:0] dexp_q[$];  // dump beats
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs_zero(input string pfx);
    check({pfx, "_ack"},   {31'd0, wb_ack_o},       32'd0);
    check({pfx, "_dat"},   wb_dat_o,                32'd0);
    check({pfx, "_rd"},    {31'd0, scal_rd_o},      32'd0);
    check({pfx, "_adr"},   {24'd0, scal_adr_o},     32'd0);
    check({pfx, "_tvld"},  {31'd0, m_tvalid},       32'd0);
    check({pfx, "_tdata"}, m_tdata,                 32'd0);
    check({pfx, "_ovr"},   {31'd0, dump_overrun_o}, 32'd0);
    check({pfx, "_state"}, {29'd0, dbg_state_o},    {29'd0, ST_IDLE});
  endtask

  // driver tasks
  task automatic wb_read(input logic [7:0] adr, input bit chk_lat);
    int n;
    bit got;
    @(negedge clk);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = adr;
    exp_q.push_back(ram[adr]);
    n = 0; got = 1'b0;
    while (!got && n < 30) begin
      @(negedge clk);
      n++;
      if (chk_lat && n == 1) begin
        check("rd_pulse", {31'd0, scal_rd_o}, 32'd1);
        check("rd_adr", {24'd0, scal_adr_o}, {24'd0, adr});
      end
      if (chk_lat && n == 2) check("rd_one_cycle", {31'd0, scal_rd_o}, 32'd0);
      if (wb_ack_o) got = 1'b1;
    end
    check("wb_ack_seen", {31'd0, got}, 32'd1);
    if (got) begin
      if (chk_lat) check("wb_latency", n, LAT + 2);
      check("wb_dat", wb_dat_o, exp_q.pop_front());
    end else begin
      void'(exp_q.pop_front());
    end
    wb_cyc = 1'b0; wb_stb = 1'b0;
    @(negedge clk);
    check("wb_ack_one_cycle", {31'd0, wb_ack_o}, 32'd0);
  endtask

  task automatic wb_write(input logic [7:0] adr);
    int n;
    bit got, saw_rd;
    @(negedge clk);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_adr = adr;
    n = 0; got = 1'b0; saw_rd = 1'b0;
    while (!got && n < 10) begin
      @(negedge clk);
      n++;
      saw_rd |= scal_rd_o;
      if (wb_ack_o) got = 1'b1;
    end
    check("wr_ack_seen", {31'd0, got}, 32'd1);
    check("wr_latency", n, 1);
    check("wr_dat_zero", wb_dat_o, 32'd0);
    check("wr_no_ram", {31'd0, saw_rd}, 32'd0);
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    @(negedge clk);
  endtask

  task automatic wb_read_abort(input logic [7:0] adr);
    bit saw_ack;
    @(negedge clk);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = adr;
    repeat (2) @(negedge clk);
    wb_stb = 1'b0;
    saw_ack = 1'b0;
    repeat (6) begin
      @(negedge clk);
      saw_ack |= wb_ack_o;
    end
    check("abort_no_ack", {31'd0, saw_ack}, 32'd0);
    check("abort_idle", {29'd0, dbg_state_o}, {29'd0, ST_IDLE});
    wb_cyc = 1'b0;
  endtask

  task automatic watch_quiet(input string tag, input int cycles);
    bit saw;
    saw = 1'b0;
    repeat (cycles) begin
      @(negedge clk);
      saw |= m_tvalid | scal_rd_o;
    end
    check(tag, {31'd0, saw}, 32'd0);
  endtask

`ifdef SCALER_DUMP_EN
  logic dump_fin;

  task automatic run_dump(input int stall_beat, input int rst_beat, input bit toggle,
                          input int ovr_beat, input bit exp_torn);
    int n;
    bit got, stable, no_rd;
    logic [31:0] held;
    for (int i = 0; i < NADDR; i++) dexp_q.push_back(ram[i]);
    @(negedge clk);
    done = 1'b1; dump_en = 1'b1;
    @(negedge clk);
    done = 1'b0;
    for (int i = 0; i < NADDR; i++) begin
      got = 1'b0; n = 0;
      while (!got && n < 100) begin
        if (m_tvalid) got = 1'b1;
        else begin
          @(negedge clk);
          n++;
        end
      end
      check("beat_seen", {31'd0, got}, 32'd1);
      if (!got) begin
        dexp_q.delete();
        return;
      end
      if (i == rst_beat) begin
        #2 wb_rst_n = 1'b0;
        #1 check_outputs_zero("rst_mid_dump");
        dexp_q.delete();
        @(negedge clk);
        wb_rst_n = 1'b1;
        return;
      end
      if (i == 5) dump_en = 1'b0;  // must not abort the running dump
      if (toggle && (i == 10 || i == 12)) write_bank = ~write_bank;
      if (i == ovr_beat) done = 1'b1;
      if (i == stall_beat) begin
        m_tready = 1'b0;
        held = m_tdata;
        stable = 1'b1; no_rd = 1'b1;
        repeat (10) begin
          @(negedge clk);
          done = 1'b0;
          stable &= m_tvalid & (m_tdata == held);
          no_rd &= ~scal_rd_o;
        end
        check("stall_stable", {31'd0, stable}, 32'd1);
        check("stall_no_rd", {31'd0, no_rd}, 32'd1);
        m_tready = 1'b1;
      end
      check("beat_data", m_tdata, dexp_q.pop_front());
      check("beat_last", {31'd0, m_tlast}, {31'd0, i == NADDR - 1});
      check("beat_user", {31'd0, m_tuser}, {31'd0, (i == NADDR - 1) && exp_torn});
      @(negedge clk);
      done = 1'b0;
    end
  endtask

  task automatic wb_hold_during_dump();
    int acks, wb_grants, dmp_grants, back_to_back, guard;
    bit prev_dmp;
    acks = 0; wb_grants = 0; dmp_grants = 0; back_to_back = 0; guard = 0;
    prev_dmp = 1'b0;
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 8'h05;
    while (!dump_fin && guard < 5000) begin
      @(negedge clk);
      guard++;
      if (scal_rd_o) begin
        if (dbg_state_o == ST_DMP_RD) begin
          if (prev_dmp) back_to_back++;
          prev_dmp = 1'b1;
          dmp_grants++;
        end else begin
          prev_dmp = 1'b0;
          wb_grants++;
        end
      end
      if (wb_ack_o) begin
        acks++;
        check("held_wb_dat", wb_dat_o, ram[5]);
      end
    end
    wb_cyc = 1'b0; wb_stb = 1'b0;
    check("contest_dmp_grants", dmp_grants, NADDR);
    check("contest_alternate", back_to_back, 0);
    check("contest_wb_served", {31'd0, wb_grants >= NADDR - 1}, 32'd1);
  endtask
`endif

  initial begin
    wb_rst_n = 1'b0;
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0; wb_adr = 8'h00;
    done = 1'b0; write_bank = 1'b0; dump_en = 1'b0; m_tready = 1'b1;
    for (int i = 0; i < 256; i++) ram[i] = $urandom;
    ram[5] = 32'h00AB_0123;

    #1 check_outputs_zero("reset");
    repeat (3) @(negedge clk);
    wb_rst_n = 1'b1;

    // directed read with latency and strobe checks
    wb_read(8'h05, 1'b1);
    wb_write(8'h22);
    // random reads
    for (int k = 0; k < 8; k++) begin
      wb_read(8'($urandom_range(0, 255)), 1'b1);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wb_read_abort(8'h07);
    wb_read(8'h05, 1'b1);

    // asynchronous reset in the middle of a read
    @(negedge clk);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 8'h09;
    repeat (2) @(negedge clk);
    #2 wb_rst_n = 1'b0;
    #1 check_outputs_zero("rst_mid_read");
    wb_cyc = 1'b0; wb_stb = 1'b0;
    @(negedge clk);
    wb_rst_n = 1'b1;
    wb_read(8'h2A, 1'b1);

`ifdef SCALER_DUMP_EN
    dump_fin = 1'b0;
    run_dump(3, -1, 1'b0, -1, 1'b0);
    check("no_overrun_yet", {31'd0, dump_overrun_o}, 32'd0);
    // disabled: done_i alone must not start a dump
    @(negedge clk);
    dump_en = 1'b0; done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    watch_quiet("dump_blocked", 12);
    // torn bank and overrun
    run_dump(-1, -1, 1'b1, 20, 1'b1);
    check("overrun_set", {31'd0, dump_overrun_o}, 32'd1);
    watch_quiet("no_restart", 15);
    // reset mid-dump, then a fresh dump from index 0
    run_dump(-1, 20, 1'b0, -1, 1'b0);
    watch_quiet("quiet_after_rst", 12);
    check("overrun_cleared", {31'd0, dump_overrun_o}, 32'd0);
    run_dump(-1, -1, 1'b0, -1, 1'b0);
    // Wishbone read held throughout a dump
    fork
      begin
        run_dump(-1, -1, 1'b0, -1, 1'b0);
        dump_fin = 1'b1;
      end
      wb_hold_during_dump();
    join
    repeat (4) @(negedge clk);
    wb_read(8'h05, 1'b1);
`else
    // dump engine absent: trigger inputs are ignored
    @(negedge clk);
    dump_en = 1'b1; done = 1'b1; m_tready = 1'b1;
    @(negedge clk);
    done = 1'b0;
    watch_quiet("no_dump_engine", 12);
    check("no_overrun", {31'd0, dump_overrun_o}, 32'd0);
    wb_read(8'h05, 1'b1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
